// File: rtl/circuit_feeder.sv
// Sample feeder for circuit: a small valid/ready FIFO drained by an FSM that
// issues one x/en strobe at a time and enforces an idle gap between strobes.
module circuit_feeder #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned GAP        = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] x,
  output logic              en,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  issued
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W    = DEPTH_LOG2 + 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]  x_q, x_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               push, pop;
  logic [DATA_W-1:0]  head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q[PTR_W-2:0]];

  assign x      = x_q;
  assign en     = en_q;
  assign issued = issued_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-2:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      en_q     <= 1'b0;
      issued_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      en_q     <= en_d;
      issued_q <= issued_d;
      gap_q    <= gap_d;
    end
  end

  // Issue control: one pop per strobe, then GAP idle cycles when GAP is non-zero.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    en_d     = 1'b0;
    gap_d    = gap_q;
    pop      = 1'b0;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          x_d     = head;
          en_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP == 0) begin
          if (!empty) begin
            pop  = 1'b1;
            x_d  = head;
            en_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d   = GAP_W'(GAP_LOAD);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (en_d) begin
      issued_d = issued_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_circuit_feeder.sv
// Bench for circuit_feeder: a GAP=1/CNT_W=16 build and a GAP=0/CNT_W=4 build,
// each checked against a queue-based model plus directed tables and sequences.
module tb_circuit_feeder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: GAP=0, CNT_W=4 build; index 1: GAP=1, CNT_W=16 build
  logic        r0, v0, y0, e0, f0, m0;
  logic        r1, v1, y1, e1, f1, m1;
  logic [31:0] d0, x0, d1, x1;
  logic [3:0]  i0;
  logic [15:0] i1;

  circuit_feeder #(.DATA_W(32), .DEPTH_LOG2(2), .GAP(0), .CNT_W(4)) u_g0 (
    .clk(clk), .rst(r0), .in_valid(v0), .in_data(d0), .in_ready(y0),
    .x(x0), .en(e0), .full(f0), .empty(m0), .issued(i0));

  circuit_feeder #(.DATA_W(32), .DEPTH_LOG2(2), .GAP(1), .CNT_W(16)) u_g1 (
    .clk(clk), .rst(r1), .in_valid(v1), .in_data(d1), .in_ready(y1),
    .x(x1), .en(e1), .full(f1), .empty(m1), .issued(i1));

  int nvec = 0;
  int nerr = 0;

  // Reference model: sample queue plus a cooldown count of edges until the next
  // strobe may be issued (GAP idle cycles plus one idle-state cycle when GAP>0).
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mx[2];
  logic        men[2];
  int unsigned miss[2];
  int          mcool[2];

  function automatic int qsz(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_step(input int k, input logic rst, input logic vld, input logic [31:0] dat);
    int gap;
    int unsigned mask;
    logic push;
    gap  = (k == 0) ? 0 : 1;
    mask = (k == 0) ? 32'hF : 32'hFFFF;
    if (rst) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      mx[k] = '0; men[k] = 1'b0; miss[k] = 0; mcool[k] = 0;
      return;
    end
    push = vld && (qsz(k) < 4);
    if (mcool[k] == 0 && qsz(k) > 0) begin
      mx[k]    = (k == 0) ? mq0.pop_front() : mq1.pop_front();
      men[k]   = 1'b1;
      miss[k]  = (miss[k] + 1) & mask;
      mcool[k] = (gap == 0) ? 0 : gap + 1;
    end else begin
      men[k] = 1'b0;
      if (mcool[k] > 0) mcool[k]--;
    end
    if (push) begin
      if (k == 0) mq0.push_back(dat); else mq1.push_back(dat);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("g0.x", x0, mx[0]);
    chk("g0.en", 32'(e0), 32'(men[0]));
    chk("g0.issued", 32'(i0), miss[0]);
    chk("g0.full", 32'(f0), 32'(qsz(0) == 4));
    chk("g0.empty", 32'(m0), 32'(qsz(0) == 0));
    chk("g0.in_ready", 32'(y0), 32'(qsz(0) != 4));
    chk("g1.x", x1, mx[1]);
    chk("g1.en", 32'(e1), 32'(men[1]));
    chk("g1.issued", 32'(i1), miss[1]);
    chk("g1.full", 32'(f1), 32'(qsz(1) == 4));
    chk("g1.empty", 32'(m1), 32'(qsz(1) == 0));
    chk("g1.in_ready", 32'(y1), 32'(qsz(1) != 4));
  endtask

  // One clock: model sees the same pre-edge inputs as the DUTs, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step(0, r0, v0, d0);
    model_step(1, r1, v1, d1);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        en;
    logic [31:0] x;
    logic [15:0] iss;
    logic        empty;
    logic        full;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [31:0] dat,
                              input logic en, input logic [31:0] x, input logic [15:0] iss,
                              input logic empty, input logic full);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.en = en;
    v.x = x; v.iss = iss; v.empty = empty; v.full = full;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [31:0] got[$];
    logic [31:0] s[4];
    logic        acc, saw_full, seen15, wrapped;
    int          n;

    // Reset, single-sample latency, then reset in the middle of a stream (GAP=1 build).
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   16'd0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   16'd0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'hA5,  1'b0, 32'h0,   16'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hA5,  16'd1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'hA5,  16'd1, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'hA5,  16'd1, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'hA5,  16'd1, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h11,  1'b0, 32'hA5,  16'd1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 32'h22,  1'b1, 32'h11,  16'd2, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h33,  1'b0, 32'h11,  16'd2, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   16'd0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   16'd0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   16'd0, 1'b1, 1'b0);

    r0 = 1'b1; v0 = 1'b0; d0 = '0;
    r1 = 1'b1; v1 = 1'b0; d1 = '0;

    foreach (tbl[i]) begin
      r1 = tbl[i].rst; v1 = tbl[i].vld; d1 = tbl[i].dat;
      tick();
      chk($sformatf("tbl%0d.en", i), 32'(e1), 32'(tbl[i].en));
      chk($sformatf("tbl%0d.x", i), x1, tbl[i].x);
      chk($sformatf("tbl%0d.issued", i), 32'(i1), 32'(tbl[i].iss));
      chk($sformatf("tbl%0d.empty", i), 32'(m1), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d.full", i), 32'(f1), 32'(tbl[i].full));
      chk($sformatf("tbl%0d.in_ready", i), 32'(y1), 32'(!tbl[i].full));
    end

    // Held valid with 1..10 on the GAP=1 build: backpressure and ordering.
    r1 = 1'b1; v1 = 1'b0; tick(); r1 = 1'b0;
    n = 1; saw_full = 1'b0;
    for (int c = 0; c < 60; c++) begin
      v1 = (n <= 10); d1 = 32'(n);
      acc = v1 && y1;
      tick();
      if (acc) n++;
      if (f1) begin
        saw_full = 1'b1;
        chk("seq.ready_while_full", 32'(y1), 32'd0);
      end
      if (e1) got.push_back(x1);
    end
    v1 = 1'b0;
    chk("seq.saw_full", 32'(saw_full), 32'd1);
    chk("seq.count", 32'(got.size()), 32'd10);
    for (int k = 0; k < 10 && k < got.size(); k++) chk($sformatf("seq.x%0d", k), got[k], 32'(k + 1));
    chk("seq.issued", 32'(i1), 32'd10);

    // Back-to-back strobes on the GAP=0 build.
    s[0] = 32'hDEAD_0000; s[1] = 32'hDEAD_0001; s[2] = 32'hDEAD_0002; s[3] = 32'hDEAD_0003;
    r0 = 1'b0; v0 = 1'b0;
    for (int t = 0; t < 6; t++) begin
      v0 = (t < 4); d0 = (t < 4) ? s[t] : 32'h0;
      tick();
      chk($sformatf("b2b%0d.en", t), 32'(e0), 32'((t >= 1) && (t <= 4)));
      chk($sformatf("b2b%0d.x", t), x0, (t == 0) ? 32'h0 : s[(t > 4) ? 3 : t - 1]);
    end
    chk("b2b.empty", 32'(m0), 32'd1);

    // 17 samples through the 4-bit issued counter: must wrap once and end at 1.
    r0 = 1'b1; tick(); r0 = 1'b0;
    n = 1; seen15 = 1'b0; wrapped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      v0 = (n <= 17); d0 = 32'(n + 100);
      acc = v0 && y0;
      tick();
      if (acc) n++;
      if (i0 == 4'd15) seen15 = 1'b1;
      if (seen15 && i0 == 4'd0) wrapped = 1'b1;
    end
    v0 = 1'b0;
    chk("wrap.seen", 32'(wrapped), 32'd1);
    chk("wrap.issued", 32'(i0), 32'd1);

    // Random traffic with occasional resets on both builds.
    for (int c = 0; c < 1500; c++) begin
      r0 = ($urandom_range(0, 63) == 0);
      r1 = ($urandom_range(0, 63) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      d0 = $urandom;
      d1 = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
